wave_sequencer: RTL and testbench
=================================

# wave_sequencer

Programmable segment sequencer for the waveform-generation path: it steps an output level through a table of up to NUM_SEG (level, dwell) segments and holds each level for a programmed number of clock cycles. It replaces the fixed two-level, fixed-period controller. It adds a writable segment table, a selectable segment count, one-shot and continuous modes, start/stop control and status outputs. It sits between the register/config interface and the DAC-side level consumer.

## Interface
- DATA_W, 13: width of output level and table levels
- CNT_W, 16: width of dwell field and internal dwell counter
- NUM_SEG, 8: segment table depth (≥2); SEG_W = $clog2(NUM_SEG)
- IDLE_LEVEL, 0: level driven on `out` whenever not running
- clock  in  1  clock; all logic on the rising edge
- reset  in  1  reset, synchronous, active-high
- cfg_we  in  1  table write strobe
- cfg_addr  in  SEG_W  segment index to write
- cfg_level  in  DATA_W  level for the written segment
- cfg_dwell  in  CNT_W  dwell for the written segment; segment lasts cfg_dwell+1 cycles
- cfg_last  in  SEG_W  index of the last active segment; sampled on accepted start
- mode  in  1  0 = continuous (wrap), 1 = one-shot; sampled on accepted start
- start  in  1  begin sequence from segment 0 (level-sampled, one cycle suffices)
- stop  in  1  abort to idle
- out  out  DATA_W  registered output level
- seg_idx  out  SEG_W  segment currently driven (0 in idle)
- seg_strobe  out  1  one-cycle pulse on the first cycle of every segment
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse on one-shot completion

## Operation
- States: IDLE, RUN.
- IDLE → RUN on start && !stop. Latch mode and min(cfg_last, NUM_SEG-1), load segment 0, cnt = 0.
- In RUN, while cnt < dwell_cur: cnt increments.
- In RUN, when cnt == dwell_cur and seg_idx < last: go to seg_idx+1, cnt = 0.
- In RUN, when cnt == dwell_cur and seg_idx == last:
  - continuous: go to segment 0, cnt = 0.
  - one-shot: go to IDLE, out = IDLE_LEVEL, pulse done.
- Any state, stop = 1: go to IDLE next edge, out = IDLE_LEVEL, seg_idx = 0, no done. Stop wins over start in the same cycle.
- start while RUN is ignored. There is no restart; stop first.
- dwell_cur and the segment level are copied from the table at segment entry. Table writes during RUN take effect the next time that segment is entered. A write on the same edge as entry to that segment is not seen on this pass.
- cfg_addr ≥ NUM_SEG: write ignored.
- Dwell width: the counter is CNT_W bits. dwell = 2^CNT_W−1 is legal and does not overflow, because the comparison is on equality.
- Reset values:
  - out = IDLE_LEVEL
  - seg_idx = 0, seg_strobe = 0, busy = 0, done = 0, state = IDLE
  - all table levels = 0, all dwells = 0

## Timing
- Start accepted at edge k: from edge k, out = level[0], busy = 1, seg_strobe = 1 for one cycle.
- Segment i drives out for exactly dwell[i]+1 cycles, back to back with no gap cycles.
- Continuous period = Σ(dwell[i]+1) for i = 0..last.
- One-shot: done and busy = 0 are asserted on the edge after the last cycle of segment `last`. out returns to IDLE_LEVEL on the same edge.
- Stop sampled at edge k: idle outputs from edge k.
- Reset mid-run: all outputs return to reset values on the next edge and the table is cleared.
- cfg_last = 0 in continuous mode: segment 0 repeats, and seg_strobe pulses every dwell[0]+1 cycles.

## Structure
- Package wave_seq_pkg holds:
  - the state enum (IDLE, RUN)
  - the mode constants MODE_CONT = 0, MODE_ONESHOT = 1
- Sub-module wave_seg_table: NUM_SEG × (DATA_W+CNT_W) register file with synchronous write, combinational read by segment index, and reset clear.
- The top level holds the FSM, the dwell counter, the latched config, and the output registers.

## Test plan
- Two-level legacy equivalent:
  - Stimulus: NUM_SEG = 8; table {0:(88,41), 1:(13,41)}; last = 1; continuous; start.
  - Response: out alternates 88/13, 42 cycles each; seg_strobe every 42 cycles; busy stays 1.
- One-shot:
  - Stimulus: levels 10, 20, 30; dwells 0, 2, 4; last = 2.
  - Response: out = 10 ×1, 20 ×3, 30 ×5 cycles. Next edge: out = 0, done pulses once, busy = 0.
- Stop mid-segment:
  - Stimulus: stop in cycle 3 of a dwell-9 segment.
  - Response: out = IDLE_LEVEL next edge; no done; start afterwards restarts at segment 0.
- Start + stop together, and start while busy:
  - Response: start+stop in the same cycle leaves the block in IDLE; start while busy leaves the sequence undisturbed.
- Live table rewrite:
  - Stimulus: write segment 1 level 99 while segment 1 is active.
  - Response: the current pass keeps the old level; the next pass shows 99.
- Edge cases:
  - cfg_addr = NUM_SEG write: ignored.
  - cfg_last = 7 with NUM_SEG = 8: uses all 8 segments.
  - dwell = 16'hFFFF: holds 65536 cycles.
  - Reset mid-run: out = 0 and the table is cleared.

Source files
------------

// File: rtl/wave_seq_pkg.sv
// Shared types and constants for the waveform segment sequencer.
package wave_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic MODE_CONT    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/wave_seg_table.sv
// Segment table: NUM_SEG entries of (level, dwell), synchronous write,
// combinational read, cleared by reset.
module wave_seg_table #(
  parameter int DATA_W  = 13,
  parameter int CNT_W   = 16,
  parameter int NUM_SEG = 8,
  parameter int SEG_W   = $clog2(NUM_SEG)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [SEG_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wlevel,
  input  logic [CNT_W-1:0]  wdwell,
  input  logic [SEG_W-1:0]  raddr,
  output logic [DATA_W-1:0] rlevel,
  output logic [CNT_W-1:0]  rdwell
);

  logic [DATA_W-1:0] level_reg [NUM_SEG];
  logic [CNT_W-1:0]  dwell_reg [NUM_SEG];

  // Addresses at or beyond NUM_SEG match no entry, so such writes are dropped.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_SEG; i++) begin
      if (reset) begin
        level_reg[i] <= '0;
        dwell_reg[i] <= '0;
      end else if (we && (waddr == SEG_W'(i))) begin
        level_reg[i] <= wlevel;
        dwell_reg[i] <= wdwell;
      end
    end
  end

  assign rlevel = level_reg[raddr];
  assign rdwell = dwell_reg[raddr];

endmodule

// File: rtl/wave_sequencer.sv
// Programmable segment sequencer: steps a registered output level through
// the segment table, holding each level for dwell+1 cycles.
module wave_sequencer
  import wave_seq_pkg::*;
#(
  parameter int              DATA_W     = 13,
  parameter int              CNT_W      = 16,
  parameter int              NUM_SEG    = 8,
  parameter logic [DATA_W-1:0] IDLE_LEVEL = '0,
  localparam int             SEG_W      = $clog2(NUM_SEG)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [SEG_W-1:0]  cfg_addr,
  input  logic [DATA_W-1:0] cfg_level,
  input  logic [CNT_W-1:0]  cfg_dwell,
  input  logic [SEG_W-1:0]  cfg_last,
  input  logic              mode,
  input  logic              start,
  input  logic              stop,
  output logic [DATA_W-1:0] out,
  output logic [SEG_W-1:0]  seg_idx,
  output logic              seg_strobe,
  output logic              busy,
  output logic              done
);

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  dwell_cur_reg;
  logic [SEG_W-1:0]  last_reg;
  logic              mode_reg;

  logic [SEG_W-1:0]  last_clamped;
  logic [SEG_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_level;
  logic [CNT_W-1:0]  rd_dwell;

  generate
    if (NUM_SEG == (1 << SEG_W)) begin : g_full_range
      assign last_clamped = cfg_last;
    end else begin : g_clamp
      assign last_clamped = (cfg_last > SEG_W'(NUM_SEG - 1)) ? SEG_W'(NUM_SEG - 1) : cfg_last;
    end
  endgenerate

  // Index of the segment to be entered next; the table is read combinationally
  // so a write landing on the entry edge is not seen until the following pass.
  assign rd_idx = (state_reg == RUN && seg_idx != last_reg) ? seg_idx + SEG_W'(1) : '0;

  wave_seg_table #(
    .DATA_W  (DATA_W),
    .CNT_W   (CNT_W),
    .NUM_SEG (NUM_SEG),
    .SEG_W   (SEG_W)
  ) u_table (
    .clock  (clock),
    .reset  (reset),
    .we     (cfg_we),
    .waddr  (cfg_addr),
    .wlevel (cfg_level),
    .wdwell (cfg_dwell),
    .raddr  (rd_idx),
    .rlevel (rd_level),
    .rdwell (rd_dwell)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      out           <= IDLE_LEVEL;
      seg_idx       <= '0;
      seg_strobe    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      cnt_reg       <= '0;
      dwell_cur_reg <= '0;
      last_reg      <= '0;
      mode_reg      <= MODE_CONT;
    end else begin
      seg_strobe <= 1'b0;
      done       <= 1'b0;
      if (stop) begin
        state_reg <= IDLE;
        out       <= IDLE_LEVEL;
        seg_idx   <= '0;
        busy      <= 1'b0;
        cnt_reg   <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              state_reg     <= RUN;
              busy          <= 1'b1;
              mode_reg      <= mode;
              last_reg      <= last_clamped;
              seg_idx       <= '0;
              out           <= rd_level;
              dwell_cur_reg <= rd_dwell;
              cnt_reg       <= '0;
              seg_strobe    <= 1'b1;
            end
          end
          RUN: begin
            // Equality compare lets dwell = all-ones run without overflow.
            if (cnt_reg != dwell_cur_reg) begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end else if (seg_idx != last_reg || mode_reg == MODE_CONT) begin
              seg_idx       <= rd_idx;
              out           <= rd_level;
              dwell_cur_reg <= rd_dwell;
              cnt_reg       <= '0;
              seg_strobe    <= 1'b1;
            end else begin
              state_reg <= IDLE;
              out       <= IDLE_LEVEL;
              seg_idx   <= '0;
              busy      <= 1'b0;
              cnt_reg   <= '0;
              done      <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wave_sequencer.sv
// Directed bench for wave_sequencer: an 8-segment instance for the main
// scenarios plus a 6-segment instance for address range and last clamping.
module tb_wave_sequencer;

  localparam int DATA_W = 13;
  localparam int CNT_W  = 16;
  localparam int SEG_W  = 3;

  logic              clock;
  logic              reset;
  logic              cfg_we;
  logic              cfg_we6;
  logic [SEG_W-1:0]  cfg_addr;
  logic [DATA_W-1:0] cfg_level;
  logic [CNT_W-1:0]  cfg_dwell;
  logic [SEG_W-1:0]  cfg_last;
  logic              mode;
  logic              start;
  logic              start6;
  logic              stop;

  logic [DATA_W-1:0] out,  out6;
  logic [SEG_W-1:0]  seg_idx, seg_idx6;
  logic              seg_strobe, seg_strobe6;
  logic              busy, busy6;
  logic              done, done6;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int check_cnt = 0;

  wave_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W), .NUM_SEG(8)) u_dut (
    .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_level(cfg_level), .cfg_dwell(cfg_dwell), .cfg_last(cfg_last),
    .mode(mode), .start(start), .stop(stop), .out(out), .seg_idx(seg_idx),
    .seg_strobe(seg_strobe), .busy(busy), .done(done)
  );

  wave_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W), .NUM_SEG(6)) u_dut6 (
    .clock(clock), .reset(reset), .cfg_we(cfg_we6), .cfg_addr(cfg_addr),
    .cfg_level(cfg_level), .cfg_dwell(cfg_dwell), .cfg_last(cfg_last),
    .mode(mode), .start(start6), .stop(stop), .out(out6), .seg_idx(seg_idx6),
    .seg_strobe(seg_strobe6), .busy(busy6), .done(done6)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [SEG_W-1:0] a, input logic [DATA_W-1:0] l, input logic [CNT_W-1:0] d);
    cfg_addr = a; cfg_level = l; cfg_dwell = d; cfg_we = 1'b1;
    tick;
    cfg_we = 1'b0;
  endtask

  task automatic wr6(input logic [SEG_W-1:0] a, input logic [DATA_W-1:0] l, input logic [CNT_W-1:0] d);
    cfg_addr = a; cfg_level = l; cfg_dwell = d; cfg_we6 = 1'b1;
    tick;
    cfg_we6 = 1'b0;
  endtask

  task automatic go(input logic [SEG_W-1:0] last, input logic m);
    cfg_last = last; mode = m; start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic halt;
    stop = 1'b1;
    tick;
    stop = 1'b0;
  endtask

  function automatic int os_level(input int t);
    if (t == 0) return 10;
    if (t <= 3) return 20;
    if (t <= 8) return 30;
    return 0;
  endfunction

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_we6 = 1'b0; cfg_addr = '0; cfg_level = '0;
    cfg_dwell = '0; cfg_last = '0; mode = 1'b0; start = 1'b0; start6 = 1'b0; stop = 1'b0;
    tick; tick;
    check("rst_out",    32'(out), 0);
    check("rst_seg",    32'(seg_idx), 0);
    check("rst_strobe", 32'(seg_strobe), 0);
    check("rst_busy",   32'(busy), 0);
    check("rst_done",   32'(done), 0);
    reset = 1'b0;
    tick;

    // Two-level legacy equivalent: 88/13 with 42 cycles each.
    wr(3'd0, 13'd88, 16'd41);
    wr(3'd1, 13'd13, 16'd41);
    go(3'd1, 1'b0);
    for (int t = 0; t < 168; t++) begin
      check("legacy_out",    32'(out), ((t % 84) < 42) ? 88 : 13);
      check("legacy_strobe", 32'(seg_strobe), (t % 42 == 0) ? 1 : 0);
      check("legacy_busy",   32'(busy), 1);
      tick;
    end
    halt;
    check("legacy_stop_out",  32'(out), 0);
    check("legacy_stop_busy", 32'(busy), 0);
    $display("step legacy two-level: checks=%0d", check_cnt);

    // One-shot 10x1, 20x3, 30x5 then done.
    wr(3'd0, 13'd10, 16'd0);
    wr(3'd1, 13'd20, 16'd2);
    wr(3'd2, 13'd30, 16'd4);
    go(3'd2, 1'b1);
    for (int t = 0; t < 9; t++) begin
      check("os_out",  32'(out), os_level(t));
      check("os_busy", 32'(busy), 1);
      check("os_done", 32'(done), 0);
      tick;
    end
    check("os_end_out",  32'(out), 0);
    check("os_end_done", 32'(done), 1);
    check("os_end_busy", 32'(busy), 0);
    tick;
    check("os_done_pulse", 32'(done), 0);
    $display("step one-shot: checks=%0d", check_cnt);

    // Stop in cycle 3 of a dwell-9 segment, then restart.
    wr(3'd1, 13'd77, 16'd9);
    go(3'd2, 1'b1);
    tick;
    check("stop_seg1_out", 32'(out), 77);
    check("stop_seg1_idx", 32'(seg_idx), 1);
    tick; tick;
    halt;
    check("stop_out",  32'(out), 0);
    check("stop_busy", 32'(busy), 0);
    check("stop_idx",  32'(seg_idx), 0);
    for (int t = 0; t < 14; t++) begin
      check("stop_no_done", 32'(done), 0);
      tick;
    end
    go(3'd2, 1'b1);
    check("restart_out",    32'(out), 10);
    check("restart_idx",    32'(seg_idx), 0);
    check("restart_strobe", 32'(seg_strobe), 1);
    repeat (16) tick;
    check("restart_done", 32'(done), 1);
    check("restart_end_out", 32'(out), 0);
    $display("step stop mid-segment: checks=%0d", check_cnt);

    // Start together with stop stays idle.
    cfg_last = 3'd2; mode = 1'b0; start = 1'b1; stop = 1'b1;
    tick;
    start = 1'b0; stop = 1'b0;
    check("ss_busy", 32'(busy), 0);
    check("ss_out",  32'(out), 0);
    tick;
    check("ss_busy2", 32'(busy), 0);

    // Start while busy is ignored.
    go(3'd2, 1'b0);
    tick; tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("sb_out",    32'(out), 77);
    check("sb_idx",    32'(seg_idx), 1);
    check("sb_strobe", 32'(seg_strobe), 0);
    repeat (8) tick;
    check("sb_seg2_out",    32'(out), 30);
    check("sb_seg2_strobe", 32'(seg_strobe), 1);
    repeat (5) tick;
    check("sb_wrap_out", 32'(out), 10);
    check("sb_wrap_idx", 32'(seg_idx), 0);
    halt;
    $display("step start/stop interplay: checks=%0d", check_cnt);

    // Live rewrite of segment 1, and a write on its entry edge.
    go(3'd2, 1'b0);
    for (int t = 0; t < 34; t++) begin
      if (t == 5)  check("live_old_level", 32'(out), 77);
      if (t == 16) check("live_wrap_out", 32'(out), 10);
      if (t == 17) check("live_new_level", 32'(out), 99);
      if (t == 17) check("live_new_strobe", 32'(seg_strobe), 1);
      if (t == 33) check("live_entry_write", 32'(out), 44);
      cfg_addr  = 3'd1;
      cfg_level = (t == 3) ? 13'd99 : 13'd44;
      cfg_dwell = 16'd9;
      cfg_we    = (t == 3) || (t == 16);
      tick;
      cfg_we = 1'b0;
    end
    halt;
    $display("step live rewrite: checks=%0d", check_cnt);

    // All eight segments with last = 7.
    for (int i = 0; i < 8; i++) wr(3'(i), 13'(100 + i), 16'd0);
    go(3'd7, 1'b0);
    for (int t = 0; t < 10; t++) begin
      check("all8_out", 32'(out), 100 + (t % 8));
      check("all8_idx", 32'(seg_idx), t % 8);
      tick;
    end
    halt;

    // Six-segment instance: out-of-range writes dropped, last clamped to 5.
    for (int i = 0; i < 6; i++) wr6(3'(i), 13'(200 + i), 16'd0);
    wr6(3'd6, 13'd250, 16'd3);
    wr6(3'd7, 13'd251, 16'd3);
    cfg_last = 3'd7; mode = 1'b0; start6 = 1'b1;
    tick;
    start6 = 1'b0;
    for (int t = 0; t < 8; t++) begin
      check("n6_out", 32'(out6), 200 + (t % 6));
      check("n6_idx", 32'(seg_idx6), t % 6);
      tick;
    end
    halt;
    check("n6_stop_busy", 32'(busy6), 0);
    $display("step range/clamp: checks=%0d", check_cnt);

    // Maximum dwell holds 65536 cycles.
    wr(3'd0, 13'd123, 16'hFFFF);
    wr(3'd1, 13'd7, 16'd0);
    go(3'd1, 1'b1);
    check("maxd_first", 32'(out), 123);
    repeat (65535) tick;
    check("maxd_last_out",    32'(out), 123);
    check("maxd_last_strobe", 32'(seg_strobe), 0);
    tick;
    check("maxd_next_out", 32'(out), 7);
    check("maxd_next_idx", 32'(seg_idx), 1);
    tick;
    check("maxd_done", 32'(done), 1);
    check("maxd_busy", 32'(busy), 0);
    $display("step max dwell: checks=%0d", check_cnt);

    // Reset mid-run clears outputs and the table.
    go(3'd0, 1'b0);
    repeat (5) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("rmr_out",    32'(out), 0);
    check("rmr_busy",   32'(busy), 0);
    check("rmr_idx",    32'(seg_idx), 0);
    check("rmr_strobe", 32'(seg_strobe), 0);
    go(3'd7, 1'b0);
    for (int t = 0; t < 4; t++) begin
      check("clr_out",    32'(out), 0);
      check("clr_strobe", 32'(seg_strobe), 1);
      check("clr_idx",    32'(seg_idx), t);
      tick;
    end
    halt;
    $display("step reset mid-run: checks=%0d", check_cnt);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
